// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-packed-BCD converter (double dabble), one input bit per clock.
// Optional leading-zero blank mask enabled by defining LEADING_ZERO_BLANK_EN.
module bin_to_bcd_seq #(
  parameter int BIN_WIDTH = 24,
  parameter int DIGITS    = 8,
  parameter int CNT_WIDTH = $clog2(BIN_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow,
  output logic [DIGITS-1:0]     digit_blank
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [BIN_WIDTH-1:0] bin_q;
  logic [4*DIGITS-1:0]  scratch_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 ovf_q;

  logic [4*DIGITS-1:0]  scratch_adj;
  logic [4*DIGITS-1:0]  shift_scratch;
  logic [BIN_WIDTH-1:0] shift_bin;
  logic                 carry_out;
  logic                 last_iter;
  logic [3:0]           digit;

  assign last_iter = (cnt_q == CNT_WIDTH'(BIN_WIDTH - 1));
  assign busy      = (state_q == SHIFT) || (state_q == DONE);
  assign done      = (state_q == DONE);

  // Add-3 is strictly per digit; a digit never carries into its neighbour.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    scratch_adj = '0;
    digit       = '0;
    for (int i = 0; i < DIGITS; i++) begin
      digit = scratch_q[4*i +: 4];
      scratch_adj[4*i +: 4] = (digit >= 4'd5) ? digit + 4'd3 : digit;
    end
  end

  // The bit leaving the top digit is the decimal carry out, i.e. overflow.
  assign {carry_out, shift_scratch, shift_bin} = {scratch_adj, bin_q, 1'b0};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_iter) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bin_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      bcd_out   <= '0;
      overflow  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            bin_q     <= bin_in;
            scratch_q <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
          end
        end
        SHIFT: begin
          bin_q     <= shift_bin;
          scratch_q <= shift_scratch;
          cnt_q     <= cnt_q + CNT_WIDTH'(1);
          ovf_q     <= ovf_q | carry_out;
          // Results land on entry to DONE so they are valid during the done pulse.
          if (last_iter) begin
            bcd_out  <= shift_scratch;
            overflow <= ovf_q | carry_out;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_d;
  logic [DIGITS-1:0] blank_q;
  logic              upper_zero;

  // Digit i>0 blanks only when it and every digit above it are zero; digit 0 never blanks.
  always_comb begin
    blank_d    = '0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      upper_zero = upper_zero & (shift_scratch[4*i +: 4] == 4'd0);
      blank_d[i] = upper_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)                             blank_q <= '0;
    else if (state_q == SHIFT && last_iter) blank_q <= blank_d;
  end

  assign digit_blank = blank_q;
`else
  assign digit_blank = '0;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: runs an 8-digit and a 6-digit instance in lockstep
// and compares both against a decimal-arithmetic reference model.
module tb_bin_to_bcd_seq;

  localparam int BW = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [BW-1:0] bin_in = '0;

  logic        busy8, done8, ovf8;
  logic [31:0] bcd8;
  logic [7:0]  blank8;
  logic        busy6, done6, ovf6;
  logic [23:0] bcd6;
  logic [5:0]  blank6;

  logic [31:0] hold_bcd8;
  logic        hold_ovf8;
  logic [7:0]  hold_blank8;
  logic [23:0] hold_bcd6;
  logic        hold_ovf6;
  logic [5:0]  hold_blank6;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.BIN_WIDTH(BW), .DIGITS(8)) dut (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
    .busy(busy8), .done(done8), .bcd_out(bcd8), .overflow(ovf8), .digit_blank(blank8)
  );

  bin_to_bcd_seq #(.BIN_WIDTH(BW), .DIGITS(6)) dut6 (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
    .busy(busy6), .done(done6), .bcd_out(bcd6), .overflow(ovf6), .digit_blank(blank6)
  );

  function automatic longint pow10(input int n);
    longint p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [31:0] model_bcd(input longint v, input int digits);
    logic [31:0] r = '0;
    longint m = v;
    for (int i = 0; i < digits; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic logic model_ovf(input longint v, input int digits);
    return (v >= pow10(digits));
  endfunction

  function automatic logic [7:0] model_blank(input longint v, input int digits);
    logic [7:0] r = '0;
`ifdef LEADING_ZERO_BLANK_EN
    longint m = v % pow10(digits);
    for (int i = 1; i < digits; i++) r[i] = (m < pow10(i));
`endif
    return r;
  endfunction

  function automatic void clear_hold();
    hold_bcd8 = '0; hold_ovf8 = 1'b0; hold_blank8 = '0;
    hold_bcd6 = '0; hold_ovf6 = 1'b0; hold_blank6 = '0;
  endfunction

  // One full conversion; poke_at>0 re-pulses start with poke_val in that busy cycle.
  task automatic run_conversion(input logic [BW-1:0] v, input int poke_at, input logic [BW-1:0] poke_val);
    logic [31:0] e8, t6;
    logic [23:0] e6;
    logic        o8, o6;
    logic [7:0]  b8, tb6;
    logic [5:0]  b6;
    logic        exp_done;
    e8 = model_bcd(longint'(v), 8);
    t6 = model_bcd(longint'(v), 6);
    e6 = t6[23:0];
    o8 = model_ovf(longint'(v), 8);
    o6 = model_ovf(longint'(v), 6);
    b8 = model_blank(longint'(v), 8);
    tb6 = model_blank(longint'(v), 6);
    b6 = tb6[5:0];

    @(negedge clk);
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || busy6 !== 1'b0 || done6 !== 1'b0) begin
      failures++;
      $display("FAIL idle_flags busy8=%b done8=%b busy6=%b done6=%b required all 0", busy8, done8, busy6, done6);
    end
    start  = 1'b1;
    bin_in = v;

    for (int cyc = 1; cyc <= BW + 1; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        start  = 1'b0;
        bin_in = ~v;
      end
      exp_done = (cyc == BW + 1);
      checks++;
      if (busy8 !== 1'b1 || busy6 !== 1'b1) begin
        failures++;
        $display("FAIL busy cycle=%0d busy8=%b busy6=%b required 1", cyc, busy8, busy6);
      end
      checks++;
      if (done8 !== exp_done || done6 !== exp_done) begin
        failures++;
        $display("FAIL done_timing cycle=%0d done8=%b done6=%b required %b", cyc, done8, done6, exp_done);
      end
      if (!exp_done) begin
        checks++;
        if (bcd8 !== hold_bcd8 || ovf8 !== hold_ovf8 || blank8 !== hold_blank8 ||
            bcd6 !== hold_bcd6 || ovf6 !== hold_ovf6 || blank6 !== hold_blank6) begin
          failures++;
          $display("FAIL hold cycle=%0d bcd8=%h/%h ovf8=%b/%b bcd6=%h/%h ovf6=%b/%b (got/required)",
                   cyc, bcd8, hold_bcd8, ovf8, hold_ovf8, bcd6, hold_bcd6, ovf6, hold_ovf6);
        end
      end else begin
        checks++;
        if (bcd8 !== e8 || ovf8 !== o8 || blank8 !== b8) begin
          failures++;
          $display("FAIL result8 bin=%0d bcd=%h ovf=%b blank=%b required bcd=%h ovf=%b blank=%b",
                   v, bcd8, ovf8, blank8, e8, o8, b8);
        end
        checks++;
        if (bcd6 !== e6 || ovf6 !== o6 || blank6 !== b6) begin
          failures++;
          $display("FAIL result6 bin=%0d bcd=%h ovf=%b blank=%b required bcd=%h ovf=%b blank=%b",
                   v, bcd6, ovf6, blank6, e6, o6, b6);
        end
      end
      if (poke_at > 0 && cyc == poke_at) begin
        start  = 1'b1;
        bin_in = poke_val;
      end else if (poke_at > 0 && cyc == poke_at + 1) begin
        start = 1'b0;
      end
    end
    hold_bcd8 = e8; hold_ovf8 = o8; hold_blank8 = b8;
    hold_bcd6 = e6; hold_ovf6 = o6; hold_blank6 = b6;
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || bcd8 !== 32'h0 || ovf8 !== 1'b0 || blank8 !== 8'h0 ||
        busy6 !== 1'b0 || done6 !== 1'b0 || bcd6 !== 24'h0 || ovf6 !== 1'b0 || blank6 !== 6'h0) begin
      failures++;
      $display("FAIL reset_state busy8=%b done8=%b bcd8=%h ovf8=%b blank8=%b bcd6=%h required all 0",
               busy8, done8, bcd8, ovf8, blank8, bcd6);
    end
    rst = 1'b1;
    clear_hold();
  endtask

  task automatic test_zero();
    run_conversion(24'd0, 0, 24'd0);
  endtask

  task automatic test_clock_time();
    run_conversion(24'd235959, 0, 24'd0);
  endtask

  task automatic test_back_to_back();
    run_conversion(24'hFFFFFF, 0, 24'd0);
    run_conversion(24'd100, 0, 24'd0);
  endtask

  task automatic test_start_ignored();
    run_conversion(24'd1234, 10, 24'd999);
  endtask

  task automatic test_abort();
    bit saw_done;
    @(negedge clk);
    start  = 1'b1;
    bin_in = 24'd59;
    for (int cyc = 1; cyc <= 11; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || bcd8 !== 32'h0 || ovf8 !== 1'b0 || blank8 !== 8'h0 ||
        busy6 !== 1'b0 || bcd6 !== 24'h0 || ovf6 !== 1'b0 || blank6 !== 6'h0) begin
      failures++;
      $display("FAIL abort_outputs busy8=%b done8=%b bcd8=%h ovf8=%b blank8=%b bcd6=%h required all 0",
               busy8, done8, bcd8, ovf8, blank8, bcd6);
    end
    saw_done = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (done8 === 1'b1 || done6 === 1'b1 || busy8 === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      failures++;
      $display("FAIL abort_no_done saw busy/done after abort=%b required 0", saw_done);
    end
    clear_hold();
    run_conversion(24'd7, 0, 24'd0);
  endtask

  task automatic test_overflow_six();
    run_conversion(24'd1000000, 0, 24'd0);
    run_conversion(24'd999999, 0, 24'd0);
  endtask

  task automatic test_random();
    logic [BW-1:0] v;
    for (int n = 0; n < 10; n++) begin
      v = BW'($urandom);
      if (n % 3 == 0) v = BW'($urandom_range(0, 9999));
      run_conversion(v, (n % 2 == 0) ? int'($urandom_range(2, BW)) : 0, BW'($urandom));
    end
  endtask

  initial begin
    clear_hold();
    test_reset();
    test_zero();
    test_clock_time();
    test_back_to_back();
    test_start_ignored();
    test_abort();
    test_overflow_six();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Sequential binary-to-packed-BCD converter (shift-and-add-3 / double dabble), one bit per clock. It sits between the clock's binary time word (hours*10000 + minutes*100 + seconds, 24 bit) and the 7-segment display driver, which needs one BCD nibble per digit. A start/done handshake lets the display side request a new conversion whenever the time word changes or on a refresh tick.

Parameters:
BIN_WIDTH, 24, width of binary input; also the number of shift iterations.
DIGITS, 8, number of BCD output digits; output width is 4*DIGITS.
CNT_WIDTH, $clog2(BIN_WIDTH+1), width of the iteration counter.

Ports:
clk  input  1  system clock, all logic on posedge.
rst  input  1  synchronous reset, active-low (0 = reset).
start  input  1  conversion request; sampled only in IDLE.
bin_in  input  BIN_WIDTH  binary value; captured on the accepted start cycle only.
busy  output  1  high from the cycle after start is accepted until done is asserted, inclusive.
done  output  1  one-cycle pulse; bcd_out/overflow valid and updated in this cycle.
bcd_out  output  4*DIGITS  packed BCD, digit 0 = bits [3:0] (least significant).
overflow  output  1  value exceeded 10^DIGITS-1; bcd_out then holds value mod 10^DIGITS.
digit_blank  output  DIGITS  per-digit blank mask (see Optional Feature).

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, busy=0, done=0, bcd_out=0, overflow=0, digit_blank=0, internal shift registers and counter cleared. Reset mid-conversion aborts it; no done pulse follows; outputs return to 0.
- States: IDLE, SHIFT, DONE.
- IDLE: if start==1, load bin shift register = bin_in, BCD scratch = 0, counter = 0, sticky ovf = 0; next state SHIFT. Otherwise stay.
- SHIFT, one iteration per cycle: every scratch digit >= 5 gets +3 (combinational). Then {scratch, binreg} shifts left 1. Any 1 shifted out of the top scratch bit sets sticky ovf. Counter increments. When counter reaches BIN_WIDTH-1 at the start of the cycle, that iteration is the last; next state DONE.
- DONE, one cycle: done=1, busy=1. bcd_out <= scratch and overflow <= sticky ovf are registered on entry, so they are valid in this cycle. Next state IDLE.
- Latency: start accepted at cycle N gives done high at cycle N+BIN_WIDTH+1. With default parameters, start at cycle 0 gives done at cycle 25. Back-to-back: start may be reasserted in the IDLE cycle after DONE, so throughput is one conversion per BIN_WIDTH+2 cycles.
- start while busy (SHIFT or DONE) is ignored, not queued. bin_in changes after capture have no effect.
- bcd_out, overflow and digit_blank hold their last values between done pulses.
- Arithmetic: the add-3 is applied per 4-bit digit and never carries between digits. Digits are always 0..9 after every iteration.

Optional Feature:
Macro LEADING_ZERO_BLANK_EN.
- Defined: in the DONE cycle, digit_blank[i]=1 for every digit i>0 whose value is 0 and all higher digits are also 0. digit_blank[0] is always 0. It is registered alongside bcd_out.
- Undefined: digit_blank tied to all-zero. No extra logic.

Test Plan:
- Reset, then start with bin_in=0 at cycle 0 -> busy cycles 1..25, done at cycle 25, bcd_out=32'h00000000, overflow=0, digit_blank=8'b11111110 with the macro (0 without).
- bin_in=235959 (23:59:59) -> bcd_out=32'h00235959, overflow=0, digit_blank=8'b11000000 with the macro.
- bin_in=24'hFFFFFF (16777215) -> bcd_out=32'h16777215, overflow=0. Then immediate restart with bin_in=100 in the following IDLE cycle -> done 25 cycles later, bcd_out=32'h00000100.
- Start bin_in=1234, pulse start again with bin_in=999 at cycle 10 -> second start ignored. A single done at cycle 25 with bcd_out=32'h00001234.
- Start bin_in=59, drive rst=0 at cycle 12 for 1 cycle -> no done pulse, outputs 0. New start with bin_in=7 -> bcd_out=32'h00000007.
- DIGITS=6, bin_in=1000000 -> overflow=1, bcd_out=24'h000000. Next conversion of 999999 -> overflow=0, bcd_out=24'h999999.
